// File: rtl/prml_ctrl_pkg.sv
// Shared types and default constants for the PRML frame controller.
package prml_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HUNT    = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_RESYNC  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int         DEF_SYNC_W      = 8;
    localparam logic [7:0] DEF_SYNC_WORD   = 8'hB1;
    localparam int         DEF_PAYLOAD_LEN = 64;
    localparam int         DEF_ERR_LIMIT   = 4;
    localparam int         DEF_HUNT_MAX    = 256;
    localparam int         DEF_CNT_W       = 8;

endpackage

// File: rtl/prml_frame_ctrl_if.sv
// Decoder/consumer-facing signal bundle of the PRML frame controller.
// master: the controller itself; slave: the decoder plus payload consumer.
interface prml_frame_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             abort;
    logic             continuous;
    logic             dec_valid;
    logic             dec_out;
    logic             dec_error;
    logic             sym_en;
    logic             dec_clear;
    logic             bit_out;
    logic             bit_valid;
    logic             frame_start;
    logic             frame_done;
    logic             sync_lost;
    logic [CNT_W-1:0] err_count;
    logic [2:0]       state_o;

    modport master (
        input  start, abort, continuous, dec_valid, dec_out, dec_error,
        output sym_en, dec_clear, bit_out, bit_valid, frame_start,
               frame_done, sync_lost, err_count, state_o
    );

    modport slave (
        output start, abort, continuous, dec_valid, dec_out, dec_error,
        input  sym_en, dec_clear, bit_out, bit_valid, frame_start,
               frame_done, sync_lost, err_count, state_o
    );
endinterface

// File: rtl/prml_sync_detect.sv
// Sync-word hunter: MSB-first shift register that restarts on a decoder
// error. 'match' reports that the value about to be loaded is the sync word.
module prml_sync_detect
    import prml_ctrl_pkg::*;
#(
    parameter int                SYNC_W    = DEF_SYNC_W,
    parameter logic [SYNC_W-1:0] SYNC_WORD = DEF_SYNC_WORD
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic shift,
    input  logic bit_in,
    input  logic error_in,
    output logic match
);
    logic [SYNC_W-1:0] sync_sr_r;
    logic [SYNC_W-1:0] sync_nxt_s;

    // Next shift-register value and look-ahead match.
    always_comb begin
        sync_nxt_s = sync_sr_r;
        match      = 1'b0;
        if (clear) begin
            sync_nxt_s = {SYNC_W{1'b0}};
        end else if (shift && error_in) begin
            sync_nxt_s = {SYNC_W{1'b0}};
        end else if (shift) begin
            sync_nxt_s = {sync_sr_r[SYNC_W-2:0], bit_in};
            match      = (sync_nxt_s == SYNC_WORD);
        end else begin
            sync_nxt_s = sync_sr_r;
        end
    end

    // Shift-register state.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_sr_r <= {SYNC_W{1'b0}};
        end else begin
            sync_sr_r <= sync_nxt_s;
        end
    end
endmodule

// File: rtl/prml_frame_ctrl.sv
// PRML Viterbi decoder sequencer: symbol strobe, decoder clear, sync hunt,
// payload framing and error-driven resync.
module prml_frame_ctrl
    import prml_ctrl_pkg::*;
#(
    parameter int                SYNC_W      = DEF_SYNC_W,
    parameter logic [SYNC_W-1:0] SYNC_WORD   = DEF_SYNC_WORD,
    parameter int                PAYLOAD_LEN = DEF_PAYLOAD_LEN,
    parameter int                ERR_LIMIT   = DEF_ERR_LIMIT,
    parameter int                HUNT_MAX    = DEF_HUNT_MAX,
    parameter int                CNT_W       = DEF_CNT_W
) (
    input  logic               clock,
    input  logic               reset,
    prml_frame_ctrl_if.master  bus
);
    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] HUNT_LAST    = CNT_W'(HUNT_MAX - 1);
    localparam logic [CNT_W-1:0] PAYLOAD_LAST = CNT_W'(PAYLOAD_LEN - 1);
    localparam logic [CNT_W-1:0] ERR_LIM      = CNT_W'(ERR_LIMIT);

    state_t           state_r;
    logic             phase_r;
    logic             sym_en_r;
    logic             dec_clear_r;
    logic             bit_out_r;
    logic             bit_valid_r;
    logic             frame_start_r;
    logic             frame_done_r;
    logic             sync_lost_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] err_r;
    logic [CNT_W-1:0] err_nxt_s;
    logic             sync_clear_s;
    logic             sync_shift_s;
    logic             sync_hit_s;

    // Saturating increment for the error counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // Sync hunter control and next error count.
    always_comb begin
        sync_clear_s = 1'b1;
        sync_shift_s = 1'b0;
        err_nxt_s    = err_r;
        if (state_r == ST_HUNT) begin
            sync_clear_s = 1'b0;
            sync_shift_s = bus.dec_valid;
        end else begin
            sync_clear_s = 1'b1;
            sync_shift_s = 1'b0;
        end
        if (bus.dec_error) begin
            err_nxt_s = sat_inc(err_r);
        end else begin
            err_nxt_s = err_r;
        end
    end

    prml_sync_detect #(
        .SYNC_W    (SYNC_W),
        .SYNC_WORD (SYNC_WORD)
    ) u_sync (
        .clock    (clock),
        .reset    (reset),
        .clear    (sync_clear_s),
        .shift    (sync_shift_s),
        .bit_in   (bus.dec_out),
        .error_in (bus.dec_error),
        .match    (sync_hit_s)
    );

    // Frame FSM with phase generator and registered pulses; HUNT entry
    // always restarts the phase so the first strobe lands in the 2nd cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            phase_r       <= 1'b0;
            sym_en_r      <= 1'b0;
            dec_clear_r   <= 1'b0;
            bit_out_r     <= 1'b0;
            bit_valid_r   <= 1'b0;
            frame_start_r <= 1'b0;
            frame_done_r  <= 1'b0;
            sync_lost_r   <= 1'b0;
            cnt_r         <= CNT_ZERO;
            err_r         <= CNT_ZERO;
        end else begin
            phase_r       <= ~phase_r;
            sym_en_r      <= ~phase_r;
            dec_clear_r   <= 1'b0;
            bit_valid_r   <= 1'b0;
            frame_start_r <= 1'b0;
            frame_done_r  <= 1'b0;
            sync_lost_r   <= 1'b0;
            if (bus.abort) begin
                state_r  <= ST_IDLE;
                phase_r  <= 1'b0;
                sym_en_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        phase_r  <= 1'b0;
                        sym_en_r <= 1'b0;
                        if (bus.start) begin
                            state_r     <= ST_HUNT;
                            dec_clear_r <= 1'b1;
                            cnt_r       <= CNT_ZERO;
                        end
                    end
                    ST_HUNT: begin
                        if (bus.dec_valid) begin
                            cnt_r <= cnt_r + CNT_ONE;
                            if (sync_hit_s) begin
                                state_r       <= ST_PAYLOAD;
                                frame_start_r <= 1'b1;
                                err_r         <= CNT_ZERO;
                                cnt_r         <= CNT_ZERO;
                            end else if (cnt_r == HUNT_LAST) begin
                                state_r     <= ST_IDLE;
                                sync_lost_r <= 1'b1;
                                phase_r     <= 1'b0;
                                sym_en_r    <= 1'b0;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        if (bus.dec_valid) begin
                            bit_out_r   <= bus.dec_out;
                            bit_valid_r <= 1'b1;
                            cnt_r       <= cnt_r + CNT_ONE;
                            err_r       <= err_nxt_s;
                            // Error limit outranks the final-bit completion.
                            if (err_nxt_s == ERR_LIM) begin
                                state_r     <= ST_RESYNC;
                                sync_lost_r <= 1'b1;
                                sym_en_r    <= 1'b0;
                            end else if (cnt_r == PAYLOAD_LAST) begin
                                state_r      <= ST_DONE;
                                frame_done_r <= 1'b1;
                            end
                        end
                    end
                    ST_RESYNC: begin
                        state_r     <= ST_HUNT;
                        dec_clear_r <= 1'b1;
                        cnt_r       <= CNT_ZERO;
                        phase_r     <= 1'b0;
                        sym_en_r    <= 1'b0;
                    end
                    ST_DONE: begin
                        phase_r  <= 1'b0;
                        sym_en_r <= 1'b0;
                        if (bus.continuous) begin
                            state_r     <= ST_HUNT;
                            dec_clear_r <= 1'b1;
                            cnt_r       <= CNT_ZERO;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_r  <= ST_IDLE;
                        phase_r  <= 1'b0;
                        sym_en_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.sym_en      = sym_en_r;
    assign bus.dec_clear   = dec_clear_r;
    assign bus.bit_out     = bit_out_r;
    assign bus.bit_valid   = bit_valid_r;
    assign bus.frame_start = frame_start_r;
    assign bus.frame_done  = frame_done_r;
    assign bus.sync_lost   = sync_lost_r;
    assign bus.err_count   = err_r;
    assign bus.state_o     = state_r;
endmodule

// File: tb/tb_prml_frame_ctrl.sv
// Directed bench for prml_frame_ctrl: a vector table for payload framing
// plus hand-written sequences for reset, hunt timeout, resync and abort.
module tb_prml_frame_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b1;

    prml_frame_ctrl_if #(.CNT_W(8)) bus ();

    prml_frame_ctrl #(
        .PAYLOAD_LEN (16),
        .ERR_LIMIT   (2),
        .HUNT_MAX    (32)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       din;
        logic       derr;
        logic [2:0] exp_state;
        logic [7:0] exp_err;
        logic       exp_done;
        logic       exp_lost;
    } vec_t;

    vec_t tbl[$];
    int   vecs  = 0;
    int   fails = 0;

    function automatic vec_t mk(input logic d, input logic e, input logic [2:0] st,
                                input logic [7:0] er, input logic dn, input logic ls);
        vec_t v;
        v.din = d; v.derr = e; v.exp_state = st;
        v.exp_err = er; v.exp_done = dn; v.exp_lost = ls;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Decoder model: after a strobe, present one result in the next cycle.
    // Returns at the falling edge just after the DUT consumed the result.
    task automatic send_bit(input logic b, input logic e, input logic ab);
        int n = 0;
        while (bus.sym_en !== 1'b1 && n < 8) begin
            @(negedge clock);
            n++;
        end
        if (bus.sym_en !== 1'b1) begin
            vecs++;
            fails++;
            $display("FAIL sym_en_timeout: got 0 expected 1 within 8 cycles");
        end else begin
            @(negedge clock);
            bus.dec_valid = 1'b1;
            bus.dec_out   = b;
            bus.dec_error = e;
            bus.abort     = ab;
            @(negedge clock);
            bus.dec_valid = 1'b0;
            bus.dec_out   = 1'b0;
            bus.dec_error = 1'b0;
        end
    endtask

    task automatic apply_vec(input int idx);
        send_bit(tbl[idx].din, tbl[idx].derr, 1'b0);
        check($sformatf("v%0d bit_valid", idx), 32'(bus.bit_valid), 32'd1);
        check($sformatf("v%0d bit_out", idx), 32'(bus.bit_out), 32'(tbl[idx].din));
        check($sformatf("v%0d state", idx), 32'(bus.state_o), 32'(tbl[idx].exp_state));
        check($sformatf("v%0d err_count", idx), 32'(bus.err_count), 32'(tbl[idx].exp_err));
        check($sformatf("v%0d frame_done", idx), 32'(bus.frame_done), 32'(tbl[idx].exp_done));
        check($sformatf("v%0d sync_lost", idx), 32'(bus.sync_lost), 32'(tbl[idx].exp_lost));
    endtask

    task automatic run_seg(input int first, input int count);
        for (int i = first; i < first + count; i++) apply_vec(i);
    endtask

    task automatic sync_and_check(input string tag);
        logic [7:0] w;
        w = 8'hB1;
        for (int i = 7; i >= 0; i--) send_bit(w[i], 1'b0, 1'b0);
        check({tag, " frame_start"}, 32'(bus.frame_start), 32'd1);
        check({tag, " state"}, 32'(bus.state_o), 32'd2);
        check({tag, " err_count"}, 32'(bus.err_count), 32'd0);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] w;
        // seg A (0..15): 16 clean alternating bits, completes the frame
        for (int i = 0; i < 16; i++)
            tbl.push_back(mk((i % 2 == 0) ? 1'b1 : 1'b0, 1'b0,
                             (i == 15) ? 3'd4 : 3'd2, 8'd0, (i == 15) ? 1'b1 : 1'b0, 1'b0));
        // seg B (16..22): errors on bits 3 and 7 -> resync on bit 7
        for (int i = 1; i <= 7; i++)
            tbl.push_back(mk(i[0], (i == 3 || i == 7) ? 1'b1 : 1'b0,
                             (i == 7) ? 3'd3 : 3'd2,
                             (i >= 7) ? 8'd2 : ((i >= 3) ? 8'd1 : 8'd0),
                             1'b0, (i == 7) ? 1'b1 : 1'b0));
        // seg C (23..38): errors on bits 5 and 16 -> last bit resyncs, no done
        for (int i = 1; i <= 16; i++)
            tbl.push_back(mk(~i[0], (i == 5 || i == 16) ? 1'b1 : 1'b0,
                             (i == 16) ? 3'd3 : 3'd2,
                             (i == 16) ? 8'd2 : ((i >= 5) ? 8'd1 : 8'd0),
                             1'b0, (i == 16) ? 1'b1 : 1'b0));
        // seg D (39..46): 8 clean bits before the abort
        for (int i = 1; i <= 8; i++)
            tbl.push_back(mk(i[1], 1'b0, 3'd2, 8'd0, 1'b0, 1'b0));

        bus.start = 1'b0; bus.abort = 1'b0; bus.continuous = 1'b0;
        bus.dec_valid = 1'b0; bus.dec_out = 1'b0; bus.dec_error = 1'b0;

        // 1. reset state, start, dec_clear/sym_en cadence, sync lock
        reset = 1'b1;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("rst state", 32'(bus.state_o), 32'd0);
        check("rst sym_en", 32'(bus.sym_en), 32'd0);
        check("rst dec_clear", 32'(bus.dec_clear), 32'd0);
        check("rst bit_valid", 32'(bus.bit_valid), 32'd0);
        check("rst frame_start", 32'(bus.frame_start), 32'd0);
        check("rst err_count", 32'(bus.err_count), 32'd0);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        check("idle state", 32'(bus.state_o), 32'd0);
        pulse_start();
        check("hunt1 state", 32'(bus.state_o), 32'd1);
        check("hunt1 dec_clear", 32'(bus.dec_clear), 32'd1);
        check("hunt1 sym_en", 32'(bus.sym_en), 32'd0);
        @(negedge clock);
        check("hunt2 dec_clear", 32'(bus.dec_clear), 32'd0);
        check("hunt2 sym_en", 32'(bus.sym_en), 32'd1);
        @(negedge clock);
        check("hunt3 sym_en", 32'(bus.sym_en), 32'd0);
        @(negedge clock);
        check("hunt4 sym_en", 32'(bus.sym_en), 32'd1);
        sync_and_check("t1");

        // 2. clean frame, continuous=0 -> IDLE
        run_seg(0, 16);
        @(negedge clock);
        check("t2 idle state", 32'(bus.state_o), 32'd0);
        check("t2 done pulse end", 32'(bus.frame_done), 32'd0);
        check("t2 idle sym_en", 32'(bus.sym_en), 32'd0);
        // clean frame, continuous=1 -> HUNT with dec_clear
        bus.continuous = 1'b1;
        pulse_start();
        @(negedge clock);
        sync_and_check("t2b");
        run_seg(0, 16);
        @(negedge clock);
        check("t2b hunt state", 32'(bus.state_o), 32'd1);
        check("t2b dec_clear", 32'(bus.dec_clear), 32'd1);
        check("t2b done pulse end", 32'(bus.frame_done), 32'd0);

        // 3. errors on bits 3 and 7 -> RESYNC one cycle, then HUNT
        sync_and_check("t3");
        run_seg(16, 7);
        @(negedge clock);
        check("t3 hunt state", 32'(bus.state_o), 32'd1);
        check("t3 dec_clear", 32'(bus.dec_clear), 32'd1);
        check("t3 err held", 32'(bus.err_count), 32'd2);
        check("t3 no done", 32'(bus.frame_done), 32'd0);

        // 4. second error on the final bit -> RESYNC, no frame_done
        sync_and_check("t4");
        run_seg(23, 16);
        @(negedge clock);
        check("t4 hunt state", 32'(bus.state_o), 32'd1);
        check("t4 no done", 32'(bus.frame_done), 32'd0);

        // 5. hunt timeout after 32 zeros
        for (int i = 1; i <= 31; i++) send_bit(1'b0, 1'b0, 1'b0);
        check("t5 bit31 state", 32'(bus.state_o), 32'd1);
        check("t5 bit31 lost", 32'(bus.sync_lost), 32'd0);
        send_bit(1'b0, 1'b0, 1'b0);
        check("t5 timeout state", 32'(bus.state_o), 32'd0);
        check("t5 timeout lost", 32'(bus.sync_lost), 32'd1);
        @(negedge clock);
        check("t5 lost pulse end", 32'(bus.sync_lost), 32'd0);
        // sync word broken by an error does not match
        pulse_start();
        w = 8'hB1;
        for (int i = 7; i >= 4; i--) begin
            send_bit(w[i], 1'b0, 1'b0);
            check($sformatf("t5 pre%0d state", i), 32'(bus.state_o), 32'd1);
        end
        send_bit(1'b0, 1'b1, 1'b0);
        check("t5 err state", 32'(bus.state_o), 32'd1);
        for (int i = 3; i >= 1; i--) begin
            send_bit(w[i], 1'b0, 1'b0);
            check($sformatf("t5 post%0d state", i), 32'(bus.state_o), 32'd1);
        end
        sync_and_check("t5");

        // 6. start ignored in PAYLOAD, abort at bit 9
        run_seg(39, 4);
        pulse_start();
        check("t6 start ignored", 32'(bus.state_o), 32'd2);
        run_seg(43, 4);
        send_bit(1'b1, 1'b0, 1'b1);
        bus.abort = 1'b0;
        check("t6 abort state", 32'(bus.state_o), 32'd0);
        check("t6 abort bit_valid", 32'(bus.bit_valid), 32'd0);
        check("t6 abort sym_en", 32'(bus.sym_en), 32'd0);
        check("t6 abort done", 32'(bus.frame_done), 32'd0);
        check("t6 abort lost", 32'(bus.sync_lost), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check($sformatf("t6 idle%0d sym_en", i), 32'(bus.sym_en), 32'd0);
            check($sformatf("t6 idle%0d bit_valid", i), 32'(bus.bit_valid), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
